// File: rtl/dodge_game_engine_if.sv
// Dodge game engine bus: control, mouse and pixel-query inputs plus game status outputs.
interface dodge_game_engine_if;
   logic        i_start;
   logic        i_mouse_valid;
   logic [7:0]  i_mouse_dx;
   logic        i_mouse_dx_neg;
   logic [8:0]  i_screen_x;
   logic [9:0]  i_screen_y;
   logic        o_is_obstacle;
   logic        o_is_player;
   logic [8:0]  o_ball_x;
   logic [15:0] o_score;
   logic [1:0]  o_state;
   logic        o_is_gameover;

   modport master (
      output i_start, i_mouse_valid, i_mouse_dx, i_mouse_dx_neg, i_screen_x, i_screen_y,
      input  o_is_obstacle, o_is_player, o_ball_x, o_score, o_state, o_is_gameover
   );

   modport slave (
      input  i_start, i_mouse_valid, i_mouse_dx, i_mouse_dx_neg, i_screen_x, i_screen_y,
      output o_is_obstacle, o_is_player, o_ball_x, o_score, o_state, o_is_gameover
   );
endinterface

// File: rtl/dodge_game_engine.sv
// Dodge game engine: player square steered by mouse deltas, falling obstacle bars with
// random gaps, tick-based scrolling that speeds up with score, and per-pixel sprite queries.
module dodge_game_engine #(
   parameter int AREA_W      = 400,
   parameter int AREA_H      = 600,
   parameter int PLAYER_SIZE = 30,
   parameter int PLAYER_Y    = 560,
   parameter int BAR_H       = 20,
   parameter int GAP_W       = 100,
   parameter int NUM_OBST    = 5,
   parameter int SPACING     = 120,
   parameter int TICK_DIV    = 65536
) (
   input  logic              clk,
   input  logic              arst_n,
   dodge_game_engine_if.slave game
);
   localparam int GAP_RANGE = AREA_W - GAP_W;
   localparam int BALL_MAX  = AREA_W - PLAYER_SIZE;
   localparam int CW        = $clog2(TICK_DIV);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;

   localparam logic [8:0]        BALL_INIT   = 9'(BALL_MAX / 2);
   localparam logic [8:0]        GAP_INIT    = 9'(GAP_RANGE / 2);
   localparam logic [8:0]        GAP_RANGE9  = 9'(GAP_RANGE);
   localparam logic signed [10:0] BALL_MAX_S = 11'(BALL_MAX);
   localparam logic [9:0]        Y_LAST      = 10'(AREA_H - 1);
   localparam logic [10:0]       PY_LO       = 11'(PLAYER_Y);
   localparam logic [10:0]       PY_HI       = 11'(PLAYER_Y + PLAYER_SIZE);
   localparam logic [10:0]       PSIZE       = 11'(PLAYER_SIZE);
   localparam logic [10:0]       BARH        = 11'(BAR_H);
   localparam logic [10:0]       GAPW        = 11'(GAP_W);
   localparam logic [CW-1:0]     CNT_ONES    = {CW{1'b1}};

   if (GAP_RANGE < 256 || GAP_RANGE > 511 || TICK_DIV < 16 ||
       (TICK_DIV & (TICK_DIV - 1)) != 0) begin : g_param_check
      $error("dodge_game_engine: AREA_W-GAP_W must be in [256,511] and TICK_DIV a power of two >= 16");
   end

   logic [1:0]          state;
   logic [8:0]          ball_x;
   logic [9:0]          obst_y [NUM_OBST];
   logic [8:0]          gap_x  [NUM_OBST];
   logic [15:0]         score;
   logic [CW-1:0]       tick_cnt;
   logic [15:0]         lfsr;

   logic [1:0]          level;
   logic [CW-1:0]       tick_last;
   logic                tick;
   logic                collide;
   logic [NUM_OBST-1:0] wrap;
   logic [7:0]          n_wrap;
   logic [16:0]         score_sum;
   logic [15:0]         score_next;
   logic [8:0]          new_gap;
   logic [15:0]         lfsr_next;
   logic signed [10:0]  mouse_sum;
   logic [8:0]          ball_next;
   logic                is_obst;
   logic                is_player;

   // Speed level, tick detection, new gap value and LFSR feedback.
   always_comb begin
      if (score[15:5] != '0 || score[4:3] == 2'b11) level = 2'd3;
      else                                         level = score[4:3];
      // TICK_DIV is a power of two, so period-1 is an all-ones mask shifted by the level.
      tick_last = CNT_ONES >> level;
      tick      = (state == S_RUN) && (tick_cnt == tick_last);
      new_gap   = (lfsr[8:0] < GAP_RANGE9) ? lfsr[8:0] : lfsr[8:0] - GAP_RANGE9;
      lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // Collision against pre-update positions, wrap detection and saturating score.
   always_comb begin
      logic [10:0] y_ext;
      logic [10:0] g_ext;
      collide = 1'b0;
      wrap    = '0;
      n_wrap  = '0;
      for (int unsigned i = 0; i < NUM_OBST; i++) begin
         y_ext = {1'b0, obst_y[i]};
         g_ext = {2'b00, gap_x[i]};
         if (y_ext < PY_HI && y_ext + BARH > PY_LO &&
             ({2'b00, ball_x} < g_ext || {2'b00, ball_x} + PSIZE > g_ext + GAPW))
            collide = 1'b1;
         wrap[i] = (obst_y[i] == Y_LAST);
         n_wrap  = n_wrap + 8'(wrap[i]);
      end
      score_sum  = {1'b0, score} + 17'(n_wrap);
      score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   // Mouse move in 11-bit signed arithmetic, clamped to the playfield.
   always_comb begin
      if (game.i_mouse_dx_neg)
         mouse_sum = $signed({2'b00, ball_x}) - $signed({3'b000, game.i_mouse_dx});
      else
         mouse_sum = $signed({2'b00, ball_x}) + $signed({3'b000, game.i_mouse_dx});
      if (mouse_sum[10])               ball_next = '0;
      else if (mouse_sum > BALL_MAX_S) ball_next = BALL_MAX_S[8:0];
      else                             ball_next = mouse_sum[8:0];
   end

   // Game state, positions, score, tick counter and free-running LFSR.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= S_IDLE;
         ball_x   <= BALL_INIT;
         score    <= '0;
         tick_cnt <= '0;
         lfsr     <= 16'hACE1;
         for (int unsigned i = 0; i < NUM_OBST; i++) begin
            obst_y[i] <= 10'(i * SPACING);
            gap_x[i]  <= GAP_INIT;
         end
      end else begin
         lfsr <= lfsr_next;
         case (state)
            S_IDLE: begin
               if (game.i_start) state <= S_RUN;
            end
            S_RUN: begin
               // A same-cycle mouse move still lands; the collision test above used the old ball_x.
               if (game.i_mouse_valid) ball_x <= ball_next;
               if (tick) begin
                  tick_cnt <= '0;
                  if (collide) begin
                     state <= S_OVER;
                  end else begin
                     score <= score_next;
                     for (int unsigned i = 0; i < NUM_OBST; i++) begin
                        if (wrap[i]) begin
                           obst_y[i] <= '0;
                           gap_x[i]  <= new_gap;
                        end else begin
                           obst_y[i] <= obst_y[i] + 10'd1;
                        end
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + CW'(1);
               end
            end
            S_OVER: begin
               if (game.i_start) begin
                  state    <= S_IDLE;
                  ball_x   <= BALL_INIT;
                  score    <= '0;
                  tick_cnt <= '0;
                  for (int unsigned i = 0; i < NUM_OBST; i++) begin
                     obst_y[i] <= 10'(i * SPACING);
                     gap_x[i]  <= GAP_INIT;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pixel queries against the current obstacle and player positions.
   always_comb begin
      logic [10:0] sx;
      logic [10:0] sy;
      logic [10:0] y_ext;
      logic [10:0] g_ext;
      sx      = {2'b00, game.i_screen_x};
      sy      = {1'b0, game.i_screen_y};
      is_obst = 1'b0;
      for (int unsigned i = 0; i < NUM_OBST; i++) begin
         y_ext = {1'b0, obst_y[i]};
         g_ext = {2'b00, gap_x[i]};
         if (sy >= y_ext && sy < y_ext + BARH && (sx < g_ext || sx >= g_ext + GAPW))
            is_obst = 1'b1;
      end
      is_player = (sx >= {2'b00, ball_x}) && (sx < {2'b00, ball_x} + PSIZE) &&
                  (sy >= PY_LO) && (sy < PY_HI);
   end

   assign game.o_is_obstacle = is_obst;
   assign game.o_is_player   = is_player;
   assign game.o_ball_x      = ball_x;
   assign game.o_score       = score;
   assign game.o_state       = state;
   assign game.o_is_gameover = (state == S_OVER);
endmodule

// File: tb/tb_dodge_game_engine.sv
// Bench for dodge_game_engine: directed scenarios plus steered and random play against a reference model.
module tb_dodge_game_engine;
   localparam int TD = 16;
   localparam int NO = 5;

   logic clk = 1'b0;
   logic arst_n = 1'b0;

   dodge_game_engine_if game_if ();

   dodge_game_engine #(.TICK_DIV(TD)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .game   (game_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_state, m_ball, m_score, m_cnt, m_lfsr;
   int m_oy [NO];
   int m_gx [NO];
   int tgt = 185;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_init(input bit with_lfsr);
      m_state = 0;
      m_ball  = (400 - 30) / 2;
      m_score = 0;
      m_cnt   = 0;
      for (int i = 0; i < NO; i++) begin
         m_oy[i] = i * 120;
         m_gx[i] = (400 - 100) / 2;
      end
      if (with_lfsr) m_lfsr = 'hACE1;
   endfunction

   function automatic void model_step(input bit s, input bit mv, input int dx, input bit neg);
      int fb, nl, lvl, period, nb, wraps, ng, lo, hi;
      bit coll;
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      nl = ((m_lfsr << 1) | fb) & 'hFFFF;
      case (m_state)
         0: if (s) m_state = 1;
         1: begin
            lvl = m_score / 8;
            if (lvl > 3) lvl = 3;
            period = TD / (1 << lvl);
            nb = m_ball;
            if (mv) begin
               nb = neg ? m_ball - dx : m_ball + dx;
               if (nb < 0) nb = 0;
               if (nb > 370) nb = 370;
            end
            if (m_cnt == period - 1) begin
               m_cnt = 0;
               coll = 0;
               for (int k = 0; k < NO; k++) begin
                  lo = (m_oy[k] > 560) ? m_oy[k] : 560;
                  hi = (m_oy[k] + 20 < 590) ? m_oy[k] + 20 : 590;
                  if (lo < hi && !(m_ball >= m_gx[k] && m_ball + 30 <= m_gx[k] + 100)) coll = 1;
               end
               if (coll) m_state = 2;
               else begin
                  ng = m_lfsr % 512;
                  if (ng >= 300) ng -= 300;
                  wraps = 0;
                  for (int k = 0; k < NO; k++) begin
                     if (m_oy[k] == 599) begin
                        m_oy[k] = 0;
                        m_gx[k] = ng;
                        wraps++;
                     end else m_oy[k]++;
                  end
                  m_score = (m_score + wraps > 65535) ? 65535 : m_score + wraps;
               end
            end else m_cnt++;
            m_ball = nb;
         end
         default: if (s) model_init(0);
      endcase
      m_lfsr = nl;
   endfunction

   function automatic int model_obst(input int x, input int y);
      for (int k = 0; k < NO; k++)
         if (y >= m_oy[k] && y < m_oy[k] + 20 && (x < m_gx[k] || x >= m_gx[k] + 100)) return 1;
      return 0;
   endfunction

   function automatic int model_player(input int x, input int y);
      return (x >= m_ball && x < m_ball + 30 && y >= 560 && y < 590) ? 1 : 0;
   endfunction

   task automatic probe(input int x, input int y);
      game_if.i_screen_x = 9'(x);
      game_if.i_screen_y = 10'(y);
      #1;
      check("obstacle_px", game_if.o_is_obstacle, model_obst(x, y));
      check("player_px", game_if.o_is_player, model_player(x, y));
   endtask

   task automatic px_expect(input string tag, input int x, input int y, input int eo, input int ep);
      game_if.i_screen_x = 9'(x);
      game_if.i_screen_y = 10'(y);
      #1;
      check({tag, "_obst"}, game_if.o_is_obstacle, eo);
      if (ep >= 0) check({tag, "_player"}, game_if.o_is_player, ep);
   endtask

   task automatic compare_all();
      int yoff [4] = '{-1, 0, 19, 20};
      int xoff [4] = '{-1, 0, 99, 100};
      int poff [4] = '{-1, 0, 29, 30};
      int prow [4] = '{559, 560, 589, 590};
      int k, x, y;
      check("state", game_if.o_state, m_state);
      check("gameover", game_if.o_is_gameover, (m_state == 2) ? 1 : 0);
      check("ball_x", game_if.o_ball_x, m_ball);
      check("score", game_if.o_score, m_score);
      k = $urandom_range(0, NO - 1);
      y = m_oy[k] + yoff[$urandom_range(0, 3)];
      if (y < 0) y = 0;
      if ($urandom_range(0, 1) == 1) x = m_gx[k] + xoff[$urandom_range(0, 3)];
      else x = $urandom_range(0, 399);
      if (x < 0) x = 0;
      probe(x, y);
      x = m_ball + poff[$urandom_range(0, 3)];
      if (x < 0) x = 0;
      y = ($urandom_range(0, 1) == 1) ? prow[$urandom_range(0, 3)] : $urandom_range(0, 599);
      probe(x, y);
   endtask

   task automatic cyc(input bit s, input bit mv, input int dx, input bit neg);
      game_if.i_start        = s;
      game_if.i_mouse_valid  = mv;
      game_if.i_mouse_dx     = 8'(dx);
      game_if.i_mouse_dx_neg = neg;
      model_step(s, mv, dx, neg);
      @(posedge clk);
      #1;
      game_if.i_start       = 1'b0;
      game_if.i_mouse_valid = 1'b0;
      compare_all();
   endtask

   // Move the ball toward a random spot inside the gap of the next obstacle to reach the player.
   task automatic steer_cyc();
      int best, by, diff;
      best = 0;
      by = -1;
      for (int k = 0; k < NO; k++)
         if (m_oy[k] < 590 && m_oy[k] > by) begin
            by = m_oy[k];
            best = k;
         end
      if (tgt < m_gx[best] || tgt > m_gx[best] + 70) tgt = m_gx[best] + $urandom_range(0, 70);
      diff = tgt - m_ball;
      if (diff == 0) cyc(0, 0, 0, 0);
      else cyc(0, 1, (diff > 0) ? ((diff > 255) ? 255 : diff) : ((-diff > 255) ? 255 : -diff), diff < 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      model_init(1);
      compare_all();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   initial begin
      int n, w, xw;
      game_if.i_start        = 1'b0;
      game_if.i_mouse_valid  = 1'b0;
      game_if.i_mouse_dx     = '0;
      game_if.i_mouse_dx_neg = 1'b0;
      game_if.i_screen_x     = '0;
      game_if.i_screen_y     = '0;
      model_init(1);
      do_reset();

      // reset pixels
      px_expect("rst_px00", 0, 0, 1, 0);
      px_expect("rst_px200_10", 200, 10, 0, 0);
      px_expect("rst_px190_570", 190, 570, 0, 1);

      // first scroll step latency
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0);
      check("first_tick_state", game_if.o_state, 1);
      px_expect("first_tick_row0", 0, 0, 0, 0);
      px_expect("first_tick_row1", 0, 1, 1, 0);
      px_expect("first_tick_row20", 0, 20, 1, 0);

      // mouse clamping
      cyc(0, 1, 255, 0);
      check("mouse_right_clamp", game_if.o_ball_x, 370);
      cyc(0, 1, 255, 1);
      check("mouse_left", game_if.o_ball_x, 115);
      cyc(0, 1, 200, 1);
      check("mouse_left_clamp", game_if.o_ball_x, 0);

      // ball at the wall: obstacle 4 collides when it reaches row 541
      n = 0;
      while (m_state != 2 && n < 3000) begin
         cyc(0, 0, 0, 0);
         n++;
      end
      check("collide_over", game_if.o_is_gameover, 1);
      px_expect("collide_bar", 0, 541, 1, -1);
      px_expect("collide_above", 0, 540, 0, -1);
      for (int i = 0; i < 40; i++) cyc(0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1));
      check("frozen_state", game_if.o_state, 2);
      check("frozen_ball", game_if.o_ball_x, 0);
      px_expect("frozen_bar", 0, 541, 1, -1);
      px_expect("frozen_above", 0, 540, 0, -1);

      // restart from OVER
      cyc(1, 0, 0, 0);
      check("restart_state", game_if.o_state, 0);
      check("restart_ball", game_if.o_ball_x, 185);
      check("restart_score", game_if.o_score, 0);
      px_expect("restart_px00", 0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      check("restart_run", game_if.o_state, 1);

      // steered play to score 8, then the tick period halves to 8
      n = 0;
      while (m_score < 8 && m_state == 1 && n < 20000) begin
         steer_cyc();
         n++;
      end
      check("score8", game_if.o_score, 8);
      w = 0;
      for (int k = 0; k < NO; k++) if (m_oy[k] == 0) w = k;
      xw = (m_gx[w] > 0) ? 0 : 399;
      for (int i = 0; i < 7; i++) steer_cyc();
      px_expect("period8_hold", xw, 0, 1, -1);
      steer_cyc();
      px_expect("period8_step_row0", xw, 0, 0, -1);
      px_expect("period8_step_row1", xw, 1, 1, -1);

      // keep going past the level saturation point
      n = 0;
      while (m_score < 26 && m_state == 1 && n < 40000) begin
         steer_cyc();
         n++;
      end
      check("score26", game_if.o_score, 26);

      // reset in the middle of a run
      do_reset();
      check("midrun_reset_state", game_if.o_state, 0);
      check("midrun_reset_score", game_if.o_score, 0);

      // random play with occasional starts and one extra reset
      for (int i = 0; i < 6000; i++) begin
         if (i == 3000) do_reset();
         cyc($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 255), $urandom_range(0, 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dodge_game_engine.md
DODGE_GAME_ENGINE -- requirements
Module: dodge_game_engine

Interface
REQ-001 Parameter AREA_W, 400, playfield width in pixels.
REQ-002 Parameter AREA_H, 600, playfield height in pixels.
REQ-003 Parameter PLAYER_SIZE, 30, player square side.
REQ-004 Parameter PLAYER_Y, 560, fixed player top row.
REQ-005 Parameter BAR_H, 20, obstacle bar height.
REQ-006 Parameter GAP_W, 100, obstacle gap width.
REQ-007 Parameter NUM_OBST, 5, obstacle count.
REQ-008 Parameter SPACING, 120, vertical pitch between obstacles.
REQ-009 Parameter TICK_DIV, 65536, base clocks per scroll step; power of two, at least 16.
REQ-010 clk  input  1  clock.
REQ-011 arst_n  input  1  reset; asynchronous, active-low.
REQ-012 i_start  input  1  start / restart pulse.
REQ-013 i_mouse_valid  input  1  mouse delta valid strobe.
REQ-014 i_mouse_dx  input  8  horizontal delta magnitude.
REQ-015 i_mouse_dx_neg  input  1  delta sign; 1 = left.
REQ-016 i_screen_x  input  9  pixel x, playfield-local.
REQ-017 i_screen_y  input  10  pixel y, playfield-local.
REQ-018 o_is_obstacle  output  1  pixel lies on an obstacle bar.
REQ-019 o_is_player  output  1  pixel lies on the player.
REQ-020 o_ball_x  output  9  player left x.
REQ-021 o_score  output  16  obstacles passed.
REQ-022 o_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 OVER.
REQ-023 o_is_gameover  output  1  high iff state is OVER.

Function
REQ-024 FSM transitions: IDLE->RUN on i_start; RUN->OVER on collision; OVER->IDLE on i_start; i_start in RUN is ignored.
REQ-025 Entering IDLE from any state reinitialises ball, obstacles, score, tick counter and level; the LFSR is not reinitialised.
REQ-026 Tick counter runs only in RUN; a tick fires when the counter reaches period-1, and the counter then returns to 0.
REQ-027 Tick period is TICK_DIV >> min(o_score[4:3]... level), where level = min(o_score/8, 3); the period halves every 8 points and saturates at TICK_DIV/8.
REQ-028 On each tick, every obstacle y increments by 1.
REQ-029 An obstacle at y = AREA_H-1 on a tick wraps to y = 0, loads a new gap_x and increments o_score by 1; o_score saturates at 16'hFFFF.
REQ-030 Multiple obstacles wrapping on the same tick each increment o_score.
REQ-031 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; it advances every clock in every state.
REQ-032 New gap_x = lfsr[8:0] if below R = AREA_W-GAP_W, else lfsr[8:0]-R; parameters SHALL satisfy 256 <= R <= 511 (elaboration assertion).
REQ-033 Mouse input, RUN only, on i_mouse_valid: ball_x <= clamp(ball_x ± i_mouse_dx, 0, AREA_W-PLAYER_SIZE); arithmetic is 11-bit signed so it cannot wrap.
REQ-034 Mouse input is ignored in IDLE and OVER.
REQ-035 Collision is evaluated on each tick using pre-update positions. A collision exists for any obstacle whose rows [y, y+BAR_H) overlap player rows [PLAYER_Y, PLAYER_Y+PLAYER_SIZE) and whose gap does not fully contain the player: ball_x < gap_x or ball_x+PLAYER_SIZE > gap_x+GAP_W.
REQ-036 On collision, obstacle motion and score for that tick are suppressed; all state then freezes in OVER.
REQ-037 A mouse update and a tick in the same cycle are permitted; collision uses the old ball_x.
REQ-038 o_is_obstacle is combinational: high if any obstacle satisfies y <= i_screen_y < y+BAR_H and i_screen_x is outside [gap_x, gap_x+GAP_W).
REQ-039 o_is_player is combinational: high if the pixel lies in [ball_x, ball_x+PLAYER_SIZE) x [PLAYER_Y, PLAYER_Y+PLAYER_SIZE).

Reset
REQ-040 Asynchronous reset sets: state IDLE; ball_x (AREA_W-PLAYER_SIZE)/2 = 185; obstacle i y = i*SPACING; every gap_x = R/2 = 150; score 0; tick counter 0; LFSR seed.
REQ-041 Reset asserted mid-RUN returns to the REQ-040 values immediately, with no pending tick.

Verification (TICK_DIV=16)
REQ-042 Reset, i_start, no mouse input -> obstacle 0 y = 1 after 17 cycles; o_state = 1.
REQ-043 RUN, ball_x = 185, dx = 255 with neg = 0 -> ball_x = 370; dx = 255 with neg = 1 -> ball_x = 115; then dx = 200 with neg = 1 -> ball_x = 0.
REQ-044 Obstacle reaches PLAYER_Y-BAR_H+1 with ball_x = 0 and gap_x = 150 -> o_is_gameover = 1 on the next tick; positions are then frozen.
REQ-045 Ball held inside the gap while 8 obstacles wrap -> o_score = 8 and the tick period becomes 8.
REQ-046 OVER, i_start -> IDLE with REQ-040 values; a second i_start -> RUN.
REQ-047 Pixel (0, 0) at reset -> o_is_obstacle = 1; pixel (200, 10) -> 0; pixel (190, 570) -> o_is_player = 1.
